regfile_sb: RTL

Parametrised successor to the core's architectural register file. It provides `N_RD` asynchronous read ports, one posedge write port with write-to-read bypass, and asynchronous active-low clear of every register. It adds a per-register busy scoreboard that raises `stall` on read-after-pending-write hazards, and a synchronised external `trigger` mirrored into a fixed register. It sits between decode (reads, issue) and writeback in the pipelined core; `a0` feeds the top-level display output.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_sb_if.sv | 41 ++++
 rtl/regfile_sb_sync2.sv | 35 +++
 rtl/regfile_sb.sv | 98 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the scoreboarded register file.
//   DATA_W_DEF   default register width
//   N_REGS_DEF   default register count (power of two)
//   N_RD_DEF     default number of read ports
//   TRIG_REG_DEF register mirrored from the synchronised trigger
//   A0_REG_DEF   register exported on a0
//   reg_addr_t   register address type for the default register count
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int N_REGS_DEF   = 32;
    localparam int N_RD_DEF     = 2;
    localparam int TRIG_REG_DEF = 5;
    localparam int A0_REG_DEF   = 10;

    typedef logic [$clog2(N_REGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback side bus of the register file.
//   rd_en/rd_addr/rd_data  N_RD read ports (data is combinational)
//   issue_valid/issue_rd   destination of the instruction in decode
//   wb_en/wb_rd/wb_data    writeback strobe, address and data
//   stall                  read-after-pending-write hazard
//   a0                     stored content of the a0 register
// The read and writeback paths have no valid/ready handshake: a read is
// served in the cycle its address is presented, and an issue is accepted
// exactly in the cycles where issue_valid is high and stall is low; a
// stalled issue is simply ignored and the producer holds it.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_REGS = N_REGS_DEF,
    parameter int N_RD   = N_RD_DEF
);
    localparam int AW = $clog2(N_REGS);

    logic [N_RD-1:0]              rd_en;
    logic [N_RD-1:0][AW-1:0]      rd_addr;
    logic [N_RD-1:0][DATA_W-1:0]  rd_data;
    logic                         issue_valid;
    logic [AW-1:0]                issue_rd;
    logic                         wb_en;
    logic [AW-1:0]                wb_rd;
    logic [DATA_W-1:0]            wb_data;
    logic                         stall;
    logic [DATA_W-1:0]            a0;

    modport master (
        output rd_en, rd_addr, issue_valid, issue_rd, wb_en, wb_rd, wb_data,
        input  rd_data, stall, a0
    );

    modport slave (
        input  rd_en, rd_addr, issue_valid, issue_rd, wb_en, wb_rd, wb_data,
        output rd_data, stall, a0
    );

endinterface

// File: rtl/regfile_sb_sync2.sv
// sync2: generic two-flop synchroniser.
//   clk    sampling clock
//   rst_n  asynchronous active-low reset, both stages clear to 0
//   d      asynchronous input
//   q      synchronised output, two posedges after d
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: architectural register file with write-to-read bypass, a
// per-register busy scoreboard and a trigger-mirroring register.
//   clk      single clock, all state changes on posedge
//   rst_n    asynchronous active-low clear of registers, busy bits, synchroniser
//   trigger  asynchronous external input, mirrored into TRIG_REG
//   bus      regfile_sb_if slave: read ports, issue, writeback, stall, a0
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int N_REGS   = N_REGS_DEF,
    parameter int N_RD     = N_RD_DEF,
    parameter int TRIG_REG = TRIG_REG_DEF,
    parameter int A0_REG   = A0_REG_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    regfile_sb_if.slave bus
);

    localparam int AW = $clog2(N_REGS);
    localparam logic [AW-1:0] TRIG_ADDR = AW'(TRIG_REG);

    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];
    logic [N_REGS-1:0] busy_q, busy_d;

    logic              trig_sync;
    logic              wb_live;
    logic              issue_fire;
    logic [N_RD-1:0]   bypass_hit;
    logic [N_RD-1:0]   hazard;

    sync2 #(.W(1)) u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trigger),
        .q     (trig_sync)
    );

    // A writeback that actually lands in storage; x0 and the trigger
    // register are never written, so they never bypass either.
    assign wb_live = bus.wb_en && (bus.wb_rd != '0) && (bus.wb_rd != TRIG_ADDR);

    genvar p;
    generate
        for (p = 0; p < N_RD; p++) begin : g_rd
            // Bypass is gated by rst_n so reads are 0 while reset is held.
            assign bypass_hit[p]  = rst_n && wb_live && (bus.wb_rd == bus.rd_addr[p]);
            assign bus.rd_data[p] = bypass_hit[p] ? bus.wb_data : regs_q[bus.rd_addr[p]];
            // A busy source is fine when its producer writes back this cycle.
            assign hazard[p]      = bus.rd_en[p] && busy_q[bus.rd_addr[p]] && !bypass_hit[p];
        end
    endgenerate

    assign bus.stall = |hazard;
    assign bus.a0    = regs_q[A0_REG];

    assign issue_fire = bus.issue_valid && !bus.stall &&
                        (bus.issue_rd != '0) && (bus.issue_rd != TRIG_ADDR);

    always_comb begin
        regs_d = regs_q;
        if (wb_live) begin
            regs_d[bus.wb_rd] = bus.wb_data;
        end
        regs_d[TRIG_REG] = {{(DATA_W-1){1'b0}}, trig_sync};
        regs_d[0]        = '0;
    end

    // Clear first, then set: an issue and a writeback to the same register in
    // one cycle means a new producer has taken it, so it stays busy.
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_en && (bus.wb_rd != '0)) begin
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0]        = 1'b0;
        busy_d[TRIG_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

endmodule
